uart_receiver: RTL and testbench

Serial-to-parallel UART receive block: the receive-side counterpart of the team's `uart_transmitter`, sharing its frame format and bit timer. It synchronises the asynchronous `rdi` line and detects a start bit, rejecting glitches. Each bit is sampled at mid-bit, and the block presents the assembled word with a one-cycle `rx_tick` strobe and a stop-bit framing status. It sits between the board RX pin and any consumer such as a FIFO or command decoder, in the same clock domain as the transmitter.

---
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receive block. It shares its frame format and bit
// timer with uart_transmitter. The asynchronous rdi line is synchronised, and
// a falling edge starts a frame. The start bit is re-checked at half a bit so
// that glitches are rejected. Each data and stop bit is sampled at mid-bit.
// The assembled word is presented with a one-cycle rx_tick strobe and a
// framing status.
//
// Parameters:
//   P     : extra bits beyond 8 (0 or 1), received raw
//   S     : number of stop bits (1 or 2)
//   TIMER : clocks per bit period (>= 4)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   rdi       in   serial line, idle high, asynchronous to clk
//   data_rx   out  last received word, LSB = first bit after start
//   rx_tick   out  one-cycle pulse when data_rx/frame_err were just updated
//   frame_err out  1 if any stop bit of the last word sampled low
// ---------------------------------------------------------------------------
module uart_receiver #(
   parameter int P     = 0,
   parameter int S     = 1,
   parameter int TIMER = 434
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rdi,
   output logic [7+P:0] data_rx,
   output logic         rx_tick,
   output logic         frame_err
);

   localparam int NB   = 8 + P;
   localparam int HALF = TIMER / 2;
   localparam int CW   = $clog2(TIMER);

   localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
   localparam logic [CW-1:0] TIMER_M1  = CW'(TIMER - 1);
   localparam logic [3:0]    LAST_DATA = 4'(NB - 1);
   localparam logic [3:0]    LAST_STOP = 4'(S - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_sync1;
   logic            r_sync2;
   logic            r_prev;
   logic [CW-1:0]   r_timer;
   logic [3:0]      r_bitCnt;
   logic [NB-1:0]   r_shift;
   logic            r_stopErr;
   logic            w_sample;

   // The sample point is half a bit into the start bit, so the start bit can
   // be re-checked. Every later bit is one full bit period after the previous
   // sample, which keeps all samples at mid-bit.
   always_comb begin
      w_sample = 1'b0;
      if (r_state == START) begin
         w_sample = (r_timer == HALF_M1);
      end else begin
         w_sample = (r_timer == TIMER_M1);
      end
   end

   // This block holds the synchroniser, the edge-detect flop and the receive
   // FSM with its bit timer and bit counter. Both counters clear on every
   // state entry. Outputs are loaded only on the final stop sample. As a
   // result, a glitch or a reset leaves data_rx and frame_err untouched, or
   // returns them to their reset values. The FSM returns to IDLE at mid-stop
   // so that a back-to-back start edge with no idle gap is still caught.
   // After a low stop bit the line is still low in IDLE. No edge is seen
   // there, so a break or stuck-low line never re-triggers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_prev    <= 1'b1;
         r_timer   <= '0;
         r_bitCnt  <= '0;
         r_shift   <= '0;
         r_stopErr <= 1'b0;
         data_rx   <= '0;
         rx_tick   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_sync1 <= rdi;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         rx_tick <= 1'b0;
         case (r_state)
            IDLE: begin
               r_timer  <= '0;
               r_bitCnt <= '0;
               if (r_prev && !r_sync2) begin
                  r_state <= START;
               end
            end
            START: begin
               if (w_sample) begin
                  r_timer  <= '0;
                  r_bitCnt <= '0;
                  if (r_sync2) begin
                     r_state <= IDLE;
                  end else begin
                     r_state <= DATA;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            DATA: begin
               if (w_sample) begin
                  r_timer <= '0;
                  r_shift <= {r_sync2, r_shift[NB-1:1]};
                  if (r_bitCnt == LAST_DATA) begin
                     r_bitCnt  <= '0;
                     r_stopErr <= 1'b0;
                     r_state   <= STOP;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            STOP: begin
               if (w_sample) begin
                  r_timer <= '0;
                  if (r_bitCnt == LAST_STOP) begin
                     data_rx   <= r_shift;
                     frame_err <= r_stopErr | ~r_sync2;
                     rx_tick   <= 1'b1;
                     r_bitCnt  <= '0;
                     r_state   <= IDLE;
                  end else begin
                     r_stopErr <= r_stopErr | ~r_sync2;
                     r_bitCnt  <= r_bitCnt + 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver. Two receivers are instantiated with
// TIMER = 16: one uses 8N1 and the other uses 9 bits with 2 stop bits. Each
// has its own ideal serial line.
//
// The reference model is a queue of expected deliveries. Each time a frame is
// driven, the bench pushes the cycle in which rx_tick must be seen, together
// with the expected word and framing status. That cycle is the drive cycle,
// plus synchroniser and edge latency, plus half a bit, plus one bit period per
// data and stop bit. One compare process checks every cycle that rx_tick
// pulses only when expected, and that the held outputs match the model.
// Directed scenarios also check literal values.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int TB_TIMER = 16;
   localparam int HALF     = TB_TIMER / 2;

   typedef struct {
      int         which;
      int         cyc;
      logic [8:0] data;
      logic       err;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       rdi0;
   logic       rdi1;
   logic [7:0] dataRx0;
   logic       rxTick0;
   logic       frameErr0;
   logic [8:0] dataRx1;
   logic       rxTick1;
   logic       frameErr1;

   int         cyc;
   int         nChecks;
   int         nErrors;
   exp_t       expQ[$];
   logic [8:0] expData [2];
   logic       expErr [2];
   int         tickSeen [2];
   int         lastTickCyc [2];
   logic       lastLevel [2];

   logic [8:0] cmpData;
   logic       cmpTick;
   logic       cmpErr;
   exp_t       cmpHead;

   uart_receiver #(.P(0), .S(1), .TIMER(TB_TIMER)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .rdi       (rdi0),
      .data_rx   (dataRx0),
      .rx_tick   (rxTick0),
      .frame_err (frameErr0)
   );

   uart_receiver #(.P(1), .S(2), .TIMER(TB_TIMER)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .rdi       (rdi1),
      .data_rx   (dataRx1),
      .rx_tick   (rxTick1),
      .frame_err (frameErr1)
   );

   // Free-running clock and cycle counter; cyc is the index of the last edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setLine(input int which, input logic v);
      if (which == 0) rdi0 = v;
      else            rdi1 = v;
   endtask

   task automatic holdBit(input int which, input logic v);
      setLine(which, v);
      waitCycles(TB_TIMER);
   endtask

   task automatic idleLine(input int which, input int n);
      setLine(which, 1'b1);
      lastLevel[which] = 1'b1;
      waitCycles(n);
   endtask

   task automatic glitch(input int which, input int len);
      setLine(which, 1'b0);
      waitCycles(len);
      idleLine(which, 2 * TB_TIMER);
   endtask

   // Drive one complete frame and record when and what it must deliver.
   task automatic applyStimulus(input int which, input logic [8:0] word,
                                input logic [1:0] stopBits, output int c0);
      int   nb;
      int   ns;
      exp_t e;
      nb = (which == 0) ? 8 : 9;
      ns = (which == 0) ? 1 : 2;
      c0 = cyc;
      e.which = which;
      e.cyc   = cyc + 3 + HALF + (nb + ns) * TB_TIMER;
      e.data  = (which == 0) ? {1'b0, word[7:0]} : word;
      e.err   = (which == 0) ? ~stopBits[0] : ~(stopBits[0] & stopBits[1]);
      expQ.push_back(e);
      holdBit(which, 1'b0);
      for (int k = 0; k < nb; k++) holdBit(which, word[k]);
      for (int j = 0; j < ns; j++) holdBit(which, stopBits[j]);
      lastLevel[which] = stopBits[ns-1];
   endtask

   // Per-cycle comparison of both receivers against the expectation queue.
   always @(negedge clk) begin
      if (reset) begin
         checkOutput("resetTick0", {31'd0, rxTick0}, 32'd0);
         checkOutput("resetData0", {24'd0, dataRx0}, 32'd0);
         checkOutput("resetErr0", {31'd0, frameErr0}, 32'd0);
         checkOutput("resetTick1", {31'd0, rxTick1}, 32'd0);
         checkOutput("resetData1", {23'd0, dataRx1}, 32'd0);
         checkOutput("resetErr1", {31'd0, frameErr1}, 32'd0);
      end else begin
         for (int d = 0; d < 2; d++) begin
            cmpData = (d == 0) ? {1'b0, dataRx0} : dataRx1;
            cmpTick = (d == 0) ? rxTick0 : rxTick1;
            cmpErr  = (d == 0) ? frameErr0 : frameErr1;
            if (cmpTick) begin
               tickSeen[d]++;
               lastTickCyc[d] = cyc;
            end
            if (expQ.size() > 0 && expQ[0].cyc == cyc && expQ[0].which == d) begin
               cmpHead = expQ.pop_front();
               checkOutput("tickPresent", {31'd0, cmpTick}, 32'd1);
               checkOutput("tickData", {23'd0, cmpData}, {23'd0, cmpHead.data});
               checkOutput("tickFrameErr", {31'd0, cmpErr}, {31'd0, cmpHead.err});
               expData[d] = cmpHead.data;
               expErr[d]  = cmpHead.err;
            end else begin
               checkOutput("noSpuriousTick", {31'd0, cmpTick}, 32'd0);
               checkOutput("holdData", {23'd0, cmpData}, {23'd0, expData[d]});
               checkOutput("holdFrameErr", {31'd0, cmpErr}, {31'd0, expErr[d]});
            end
         end
         if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            cmpHead = expQ.pop_front();
            checkOutput("missedTickCycle", cyc, cmpHead.cyc);
         end
      end
   end

   initial begin
      int         c0;
      int         t;
      int         w;
      int         gap;
      logic [8:0] word;
      logic [1:0] stops;

      nChecks = 0;
      nErrors = 0;
      expData = '{9'd0, 9'd0};
      expErr = '{1'b0, 1'b0};
      tickSeen = '{0, 0};
      lastTickCyc = '{0, 0};
      lastLevel = '{1'b1, 1'b1};
      reset = 1'b1;
      rdi0  = 1'b1;
      rdi1  = 1'b1;
      waitCycles(4);
      reset = 1'b0;
      idleLine(0, 5);

      // Basic 8N1 receive of 0xA5 with pinned latency.
      t = tickSeen[0];
      applyStimulus(0, 9'h0A5, 2'b11, c0);
      checkOutput("basicData", {24'd0, dataRx0}, 32'h0A5);
      checkOutput("basicErr", {31'd0, frameErr0}, 32'd0);
      checkOutput("basicTickCount", tickSeen[0] - t, 32'd1);
      checkOutput("basicLatency", lastTickCyc[0] - c0, 32'd155);

      // Short glitch must not deliver anything.
      idleLine(0, 5);
      t = tickSeen[0];
      glitch(0, 3);
      checkOutput("glitchNoTick", tickSeen[0] - t, 32'd0);
      checkOutput("glitchDataKept", {24'd0, dataRx0}, 32'h0A5);

      // Framing error, then recovery after the line returns high.
      applyStimulus(0, 9'h03C, 2'b00, c0);
      checkOutput("ferrData", {24'd0, dataRx0}, 32'h03C);
      checkOutput("ferrFlag", {31'd0, frameErr0}, 32'd1);
      idleLine(0, 10);
      applyStimulus(0, 9'h055, 2'b11, c0);
      checkOutput("ferrClearData", {24'd0, dataRx0}, 32'h055);
      checkOutput("ferrClearFlag", {31'd0, frameErr0}, 32'd0);

      // Back-to-back frames with no idle gap.
      idleLine(0, 3);
      t = tickSeen[0];
      applyStimulus(0, 9'h000, 2'b11, c0);
      applyStimulus(0, 9'h0FF, 2'b11, c0);
      checkOutput("b2bTickCount", tickSeen[0] - t, 32'd2);
      checkOutput("b2bData", {24'd0, dataRx0}, 32'h0FF);
      checkOutput("b2bErr", {31'd0, frameErr0}, 32'd0);

      // Wide format: 9 data bits, 2 stop bits.
      idleLine(1, 5);
      applyStimulus(1, 9'h1B5, 2'b11, c0);
      checkOutput("wideData", {23'd0, dataRx1}, 32'h1B5);
      checkOutput("wideErr", {31'd0, frameErr1}, 32'd0);
      checkOutput("wideLatency", lastTickCyc[1] - c0, 32'd187);
      idleLine(1, 5);
      applyStimulus(1, 9'h1B5, 2'b01, c0);
      checkOutput("wideStop2Err", {31'd0, frameErr1}, 32'd1);
      idleLine(1, 5);

      // Reset during data bit 4 of 0x81, then receive 0x7E.
      idleLine(0, 5);
      t = tickSeen[0];
      word = 9'h081;
      holdBit(0, 1'b0);
      for (int k = 0; k < 4; k++) holdBit(0, word[k]);
      setLine(0, word[4]);
      waitCycles(HALF);
      reset = 1'b1;
      expQ.delete();
      expData = '{9'd0, 9'd0};
      expErr = '{1'b0, 1'b0};
      setLine(0, 1'b1);
      #1;
      checkOutput("midRstData0", {24'd0, dataRx0}, 32'd0);
      checkOutput("midRstData1", {23'd0, dataRx1}, 32'd0);
      checkOutput("midRstErr1", {31'd0, frameErr1}, 32'd0);
      waitCycles(5);
      reset = 1'b0;
      idleLine(0, 5);
      checkOutput("midRstNoTick", tickSeen[0] - t, 32'd0);
      applyStimulus(0, 9'h07E, 2'b11, c0);
      checkOutput("postRstData", {24'd0, dataRx0}, 32'h07E);
      checkOutput("postRstTickCount", tickSeen[0] - t, 32'd1);

      // Randomized frames, stop bits, gaps and glitches on both receivers.
      for (int i = 0; i < 40; i++) begin
         w = $urandom_range(0, 1);
         if (lastLevel[w] == 1'b0) idleLine(w, 3);
         if ($urandom_range(0, 7) == 0) glitch(w, $urandom_range(1, 4));
         word  = 9'($urandom);
         stops = 2'b11;
         if ($urandom_range(0, 6) == 0) stops[0] = 1'b0;
         if ($urandom_range(0, 6) == 0) stops[1] = 1'b0;
         applyStimulus(w, word, stops, c0);
         gap = $urandom_range(0, 20);
         if (lastLevel[w] == 1'b0 && gap < 3) gap = 3;
         if (gap > 0) idleLine(w, gap);
      end

      idleLine(0, 2 * TB_TIMER);
      idleLine(1, 2 * TB_TIMER);
      checkOutput("queueDrained", expQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
